// File: rtl/saph_fpu_arbiter_if.sv
// saph_fpu_arbiter_if: requester, FPU lane and response signals of the FPU arbiter.
interface saph_fpu_arbiter_if #(
  parameter int REQS = 2,
  parameter int OPW  = 4
);
  logic [REQS-1:0]           req_valid;
  logic [REQS-1:0]           req_ready;
  logic [REQS-1:0][OPW-1:0]  req_op;
  logic [REQS-1:0][31:0]     req_a;
  logic [REQS-1:0][31:0]     req_b;
  logic                      fpu_valid;
  logic                      fpu_ready;
  logic [OPW-1:0]            fpu_op;
  logic [31:0]               fpu_a;
  logic [31:0]               fpu_b;
  logic                      fpu_res_valid;
  logic [31:0]               fpu_res;
  logic [REQS-1:0]           rsp_valid;
  logic [31:0]               rsp_data;
  logic                      busy;
  logic                      err;
  modport slave (
    input  req_valid, req_op, req_a, req_b, fpu_ready, fpu_res_valid, fpu_res,
    output req_ready, fpu_valid, fpu_op, fpu_a, fpu_b, rsp_valid, rsp_data, busy, err
  );
  modport master (
    output req_valid, req_op, req_a, req_b, fpu_ready, fpu_res_valid, fpu_res,
    input  req_ready, fpu_valid, fpu_op, fpu_a, fpu_b, rsp_valid, rsp_data, busy, err
  );
endinterface

// File: rtl/saph_fpu_arbiter.sv
// saph_fpu_arbiter: round-robin share of one FPU issue lane with an in-order tag FIFO routing results back.
module saph_fpu_arbiter #(
  parameter int REQS  = 2,
  parameter int OPW   = 4,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  saph_fpu_arbiter_if.slave bus
);
  localparam int IW = $clog2(REQS);
  localparam int AW = $clog2(DEPTH);
  logic [IW-1:0]   rr, gnt, jj;
  logic [IW-1:0]   tags [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [AW:0]     cnt;
  logic            full, empty, issue, pop;
  logic [REQS-1:0] one;
  int              j;
  // Scan from the farthest offset down so the nearest valid index at or after rr wins.
  always_comb begin
    gnt = rr;
    j = 0;
    jj = '0;
    for (int k = REQS - 1; k >= 0; k--) begin
      j = int'(rr) + k;
      j = j >= REQS ? j - REQS : j;
      jj = IW'(j);
      gnt = bus.req_valid[jj] ? jj : gnt;
    end
  end
  assign one           = {{(REQS-1){1'b0}}, 1'b1};
  assign full          = cnt == (AW+1)'(DEPTH);
  assign empty         = cnt == '0;
  assign bus.fpu_valid = (|bus.req_valid) & ~full & ~rst;
  assign issue         = bus.fpu_valid & bus.fpu_ready;
  assign bus.req_ready = issue ? one << gnt : '0;
  assign bus.fpu_op    = bus.req_op[gnt];
  assign bus.fpu_a     = bus.req_a[gnt];
  assign bus.fpu_b     = bus.req_b[gnt];
  assign pop           = bus.fpu_res_valid & ~empty;
  assign bus.busy      = ~empty;
  always_ff @(posedge clk)
    if (issue) tags[wp] <= gnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      rr            <= '0;
      wp            <= '0;
      rp            <= '0;
      cnt           <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      bus.err       <= 1'b0;
    end else begin
      wp            <= issue ? wp + 1'b1 : wp;
      rr            <= issue ? (gnt == IW'(REQS - 1) ? '0 : gnt + 1'b1) : rr;
      rp            <= pop ? rp + 1'b1 : rp;
      cnt           <= cnt + (AW+1)'(issue) - (AW+1)'(pop);
      bus.rsp_valid <= pop ? one << tags[rp] : '0;
      bus.rsp_data  <= pop ? bus.fpu_res : bus.rsp_data;
      bus.err       <= bus.err | (bus.fpu_res_valid & empty);
    end
  end
endmodule

// File: tb/tb_saph_fpu_arbiter.sv
// tb_saph_fpu_arbiter: directed and random stimulus checked against a queue-based reference model.
module tb_saph_fpu_arbiter;
  localparam int REQS  = 2;
  localparam int OPW   = 4;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  saph_fpu_arbiter_if #(.REQS(REQS), .OPW(OPW)) bus ();
  saph_fpu_arbiter #(.REQS(REQS), .OPW(OPW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int              total = 0;
  int              bad = 0;
  int              rr_m;
  int              q[$];
  logic            err_m;
  logic [REQS-1:0] rv_m;
  logic [31:0]     rd_m;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int grant();
    for (int k = 0; k < REQS; k++)
      if (bus.req_valid[(rr_m + k) % REQS]) return (rr_m + k) % REQS;
    return -1;
  endfunction
  task automatic step(logic r, logic [REQS-1:0] v, logic rdy, logic resv, logic [31:0] res);
    int   g;
    logic can;
    rst = r;
    bus.req_valid = v;
    bus.fpu_ready = rdy;
    bus.fpu_res_valid = resv;
    bus.fpu_res = res;
    for (int i = 0; i < REQS; i++) begin
      bus.req_op[i] = OPW'($urandom);
      bus.req_a[i] = $urandom;
      bus.req_b[i] = $urandom;
    end
    @(negedge clk);
    g = grant();
    can = !r && g >= 0 && q.size() < DEPTH;
    check("fpu_valid", 32'(bus.fpu_valid), 32'(can));
    check("req_ready", 32'(bus.req_ready), (can && rdy) ? 32'(1) << g : 32'(0));
    if (can) begin
      check("fpu_op", 32'(bus.fpu_op), 32'(bus.req_op[g]));
      check("fpu_a", bus.fpu_a, bus.req_a[g]);
      check("fpu_b", bus.fpu_b, bus.req_b[g]);
    end
    check("rsp_valid", 32'(bus.rsp_valid), 32'(rv_m));
    check("rsp_data", bus.rsp_data, rd_m);
    check("busy", 32'(bus.busy), 32'(q.size() != 0));
    check("err", 32'(bus.err), 32'(err_m));
    @(posedge clk);
    if (r) begin
      rr_m = 0; q.delete(); err_m = 1'b0; rv_m = '0; rd_m = '0;
    end else begin
      rv_m = '0;
      if (resv && q.size() == 0) err_m = 1'b1;
      else if (resv) begin
        rv_m = REQS'(1) << q.pop_front();
        rd_m = res;
      end
      if (can && rdy) begin
        q.push_back(g);
        rr_m = (g + 1) % REQS;
      end
    end
    #1;
  endtask
  initial begin
    rst = 1'b1;
    bus.req_valid = '0; bus.fpu_ready = 1'b0; bus.fpu_res_valid = 1'b0; bus.fpu_res = '0;
    bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    rr_m = 0; err_m = 1'b0; rv_m = '0; rd_m = '0;
    repeat (2) @(posedge clk);
    #1;
    step(0, 2'b00, 1, 0, 0);
    // single request, result three cycles later
    step(0, 2'b01, 1, 0, 0);
    repeat (3) step(0, 2'b00, 1, 0, 0);
    step(0, 2'b00, 1, 1, 32'h3F9147AE);
    step(0, 2'b00, 1, 0, 0);
    // contention then in-order results
    repeat (4) step(0, 2'b11, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 2'b00, 1, 1, 32'hA000_0000 + i);
    step(0, 2'b00, 1, 0, 0);
    // fill, blocked fifth, pop with same-cycle request, then resume
    repeat (5) step(0, 2'b11, 1, 0, 0);
    step(0, 2'b11, 1, 1, 32'h1234_5678);
    step(0, 2'b11, 1, 0, 0);
    // backpressure
    repeat (3) step(0, 2'b11, 0, 0, 0);
    // reset mid-flight, then requester 1 alone
    step(1, 2'b11, 1, 0, 0);
    step(0, 2'b01, 1, 0, 0);
    step(0, 2'b10, 1, 0, 0);
    step(1, 2'b00, 1, 0, 0);
    step(0, 2'b10, 1, 0, 0);
    step(1, 2'b00, 1, 0, 0);
    // stray result sets a sticky err, issue in same cycle does not count
    step(0, 2'b01, 1, 1, 32'hDEAD_BEEF);
    repeat (10) step(0, 2'b00, 1, 0, 0);
    step(1, 2'b00, 1, 0, 0);
    step(0, 2'b00, 1, 0, 0);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 99) == 0, REQS'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 3, $urandom);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
